// File: rtl/axi_route_pkg.sv
// Shared definitions for the AXI write-path route control.
// Route state enum, route code helper, slave address map and M*_S*_W codes.
`ifndef AXI_ROUTE_MACROS
`define AXI_ROUTE_MACROS
`define AXI_ADDR_BITS 32
`define MX_SX_ID_BITS 5
`define M0_S0_W 5'd1
`define M0_S1_W 5'd2
`define M0_S2_W 5'd3
`define M0_S3_W 5'd4
`define M0_S4_W 5'd5
`define M0_S5_W 5'd6
`define M0_S6_W 5'd7
`define M0_S7_W 5'd8
`define M1_S0_W 5'd9
`define M1_S1_W 5'd10
`define M1_S2_W 5'd11
`define M1_S3_W 5'd12
`define M1_S4_W 5'd13
`define M1_S5_W 5'd14
`define M1_S6_W 5'd15
`define M1_S7_W 5'd16
`define M2_S0_W 5'd17
`define M2_S1_W 5'd18
`define M2_S2_W 5'd19
`define M2_S3_W 5'd20
`define M2_S4_W 5'd21
`define M2_S5_W 5'd22
`define M2_S6_W 5'd23
`define M2_S7_W 5'd24
`endif

package axi_route_pkg;

    localparam int CODE_W      = 5;
    localparam int NUM_M       = 3;
    localparam int NUM_S       = 8;
    localparam int DEFAULT_SLV = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } route_state_e;

    // Address map of S0..S6; S7 takes every miss.
    localparam logic [31:0] SLV_BASE [7] = '{
        32'h0000_0000,
        32'h0001_0000,
        32'h0002_0000,
        32'h1000_0000,
        32'h1001_0000,
        32'h2000_0000,
        32'h3000_0000
    };

    localparam logic [31:0] SLV_MASK [7] = '{
        32'hFFFF_C000,
        32'hFFFF_0000,
        32'hFFFF_0000,
        32'hFFFF_FC00,
        32'hFFFF_FC00,
        32'hFFE0_0000,
        32'hFFFF_0000
    };

    // Route code = 1 + 8*m + s; {m, s} already equals 8*m + s.
    function automatic logic [CODE_W-1:0] code(
        input logic [1:0] m,
        input logic [2:0] s
    );
        return {m, s} + CODE_W'(1);
    endfunction

endpackage

// File: rtl/aw_addr_decoder.sv
// Combinational AW address decoder: first base/mask match among S0..S6.
// Ports: addr (ADDR_W) in, slv (3-bit slave index) out; misses give S7.
module aw_addr_decoder
    import axi_route_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [2:0]        slv
);

    // Walk downwards so the lowest matching index is written last.
    always_comb begin
        slv = 3'(DEFAULT_SLV);
        for (int i = NUM_S - 2; i >= 0; i--) begin
            if ((addr & ADDR_W'(SLV_MASK[i])) == ADDR_W'(SLV_BASE[i])) begin
                slv = 3'(i);
            end
        end
    end

endmodule

// File: rtl/write_addr_arbiter.sv
// AW arbiter/router: grants one of M0..M2, decodes the slave, holds the
// route code until the B handshake. One outstanding write at a time.
// Ports: ACLK, ARESETn (async low), AWVALID_M[2:0], AWADDR_M0..2,
//   AWREADY_S/WVALID_S/WREADY_S/WLAST_S[7:0], BVALID_M/BREADY_M[2:0],
//   AW_arbiter (route code, 0 = none), aw_busy (state != IDLE).
// Define AW_RR_ARB_EN for round-robin; otherwise fixed M0 > M1 > M2.
module write_addr_arbiter #(
    parameter int ADDR_W = `AXI_ADDR_BITS,
    parameter int CODE_W = `MX_SX_ID_BITS
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [2:0]        AWVALID_M,
    input  logic [ADDR_W-1:0] AWADDR_M0,
    input  logic [ADDR_W-1:0] AWADDR_M1,
    input  logic [ADDR_W-1:0] AWADDR_M2,
    input  logic [7:0]        AWREADY_S,
    input  logic [7:0]        WVALID_S,
    input  logic [7:0]        WREADY_S,
    input  logic [7:0]        WLAST_S,
    input  logic [2:0]        BVALID_M,
    input  logic [2:0]        BREADY_M,
    output logic [CODE_W-1:0] AW_arbiter,
    output logic              aw_busy
);

    import axi_route_pkg::*;

    route_state_e      state;
    route_state_e      state_nxt;

    logic [1:0]        grant;
    logic [1:0]        grant_nxt;
    logic [2:0]        slv;
    logic [2:0]        slv_nxt;
    logic              wlast_seen;
    logic              wlast_nxt;
    logic [CODE_W-1:0] code_nxt;
    logic              busy_nxt;

    logic              any_req;
    logic [1:0]        win;
    logic [ADDR_W-1:0] win_addr;
    logic [2:0]        dec_slv;

    logic              aw_hs;
    logic              wl_hs;
    logic              b_hs;

    assign any_req = |AWVALID_M;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef AW_RR_ARB_EN
    logic [1:0] rr_ptr;
    logic [1:0] rr_nxt;

    function automatic logic [1:0] rr_at(
        input logic [1:0] p,
        input int         k
    );
        int j;
        j = int'(p) + k;
        if (j >= 3) begin
            j = j - 3;
        end
        return 2'(j);
    endfunction

    // rr_ptr holds the highest-priority master; last write wins.
    always_comb begin
        win = rr_ptr;
        for (int k = 2; k >= 0; k--) begin
            if (AWVALID_M[rr_at(rr_ptr, k)]) begin
                win = rr_at(rr_ptr, k);
            end
        end
    end

    assign rr_nxt = (win == 2'd2) ? 2'd0 : win + 2'd1;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rr_ptr <= 2'd0;
        end else if (state == ST_IDLE && any_req) begin
            rr_ptr <= rr_nxt;
        end
    end
`else
    always_comb begin
        win = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (AWVALID_M[k]) begin
                win = 2'(k);
            end
        end
    end
`endif

    always_comb begin
        unique case (win)
            2'd1:    win_addr = AWADDR_M1;
            2'd2:    win_addr = AWADDR_M2;
            default: win_addr = AWADDR_M0;
        endcase
    end

    aw_addr_decoder #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .addr (win_addr),
        .slv  (dec_slv)
    );

    // ------------------------------------------------------------------
    // Handshakes on the held route
    // ------------------------------------------------------------------
    assign aw_hs = AWVALID_M[grant] & AWREADY_S[slv];
    assign wl_hs = WVALID_S[slv] & WREADY_S[slv] & WLAST_S[slv];
    assign b_hs  = BVALID_M[grant] & BREADY_M[grant];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // W may finish before AW; then the AW handshake ends the burst.
                if (aw_hs && (wl_hs || wlast_seen)) begin
                    state_nxt = ST_RESP;
                end else if (aw_hs) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (wl_hs) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (b_hs) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        grant_nxt = grant;
        slv_nxt   = slv;
        wlast_nxt = wlast_seen;
        code_nxt  = AW_arbiter;
        busy_nxt  = (state_nxt != ST_IDLE);
        unique case (state)
            ST_IDLE: begin
                if (any_req) begin
                    grant_nxt = win;
                    slv_nxt   = dec_slv;
                    wlast_nxt = 1'b0;
                    code_nxt  = CODE_W'(code(win, dec_slv));
                end
            end
            ST_ADDR: begin
                if (!aw_hs && wl_hs) begin
                    wlast_nxt = 1'b1;
                end
            end
            ST_DATA: begin
                wlast_nxt = wlast_seen;
            end
            ST_RESP: begin
                if (b_hs) begin
                    wlast_nxt = 1'b0;
                    code_nxt  = '0;
                end
            end
            default: begin
                wlast_nxt = 1'b0;
                code_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            grant      <= 2'd0;
            slv        <= 3'd0;
            wlast_seen <= 1'b0;
            AW_arbiter <= '0;
            aw_busy    <= 1'b0;
        end else begin
            grant      <= grant_nxt;
            slv        <= slv_nxt;
            wlast_seen <= wlast_nxt;
            AW_arbiter <= code_nxt;
            aw_busy    <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_write_addr_arbiter.sv
// Directed self-checking bench for write_addr_arbiter.
// Expectations follow AW_RR_ARB_EN when it is defined.
module tb_write_addr_arbiter;

    logic        ACLK;
    logic        ARESETn;
    logic [2:0]  AWVALID_M;
    logic [31:0] AWADDR_M0;
    logic [31:0] AWADDR_M1;
    logic [31:0] AWADDR_M2;
    logic [7:0]  AWREADY_S;
    logic [7:0]  WVALID_S;
    logic [7:0]  WREADY_S;
    logic [7:0]  WLAST_S;
    logic [2:0]  BVALID_M;
    logic [2:0]  BREADY_M;
    logic [4:0]  AW_arbiter;
    logic        aw_busy;

    int checks;
    int failures;

    write_addr_arbiter dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .AWVALID_M  (AWVALID_M),
        .AWADDR_M0  (AWADDR_M0),
        .AWADDR_M1  (AWADDR_M1),
        .AWADDR_M2  (AWADDR_M2),
        .AWREADY_S  (AWREADY_S),
        .WVALID_S   (WVALID_S),
        .WREADY_S   (WREADY_S),
        .WLAST_S    (WLAST_S),
        .BVALID_M   (BVALID_M),
        .BREADY_M   (BREADY_M),
        .AW_arbiter (AW_arbiter),
        .aw_busy    (aw_busy)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_inputs();
        AWVALID_M = '0;
        AWADDR_M0 = '0;
        AWADDR_M1 = '0;
        AWADDR_M2 = '0;
        AWREADY_S = '0;
        WVALID_S  = '0;
        WREADY_S  = '0;
        WLAST_S   = '0;
        BVALID_M  = '0;
        BREADY_M  = '0;
    endtask

    task automatic apply_reset();
        ARESETn = 1'b0;
        clear_inputs();
        tick();
        tick();
        ARESETn = 1'b1;
        tick();
    endtask

    // From ADDR: AW and W-last together, then B; leaves the FSM in IDLE.
    task automatic finish_burst(input int m, input int s);
        AWVALID_M[m] = 1'b1;
        AWREADY_S[s] = 1'b1;
        WVALID_S[s]  = 1'b1;
        WREADY_S[s]  = 1'b1;
        WLAST_S[s]   = 1'b1;
        tick();
        AWVALID_M    = '0;
        AWREADY_S    = '0;
        WVALID_S     = '0;
        WREADY_S     = '0;
        WLAST_S      = '0;
        BVALID_M[m]  = 1'b1;
        BREADY_M[m]  = 1'b1;
        tick();
        BVALID_M     = '0;
        BREADY_M     = '0;
    endtask

    task automatic test_reset();
        ARESETn   = 1'b0;
        AWVALID_M = 3'b111;
        AWADDR_M0 = 32'h0001_0000;
        tick();
        tick();
        checks++;
        if (AW_arbiter !== 5'd0) begin
            failures++;
            $display("FAIL reset_code: got %0d expected 0", AW_arbiter);
        end
        checks++;
        if (aw_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %0b expected 0", aw_busy);
        end
    endtask

    task automatic test_single();
        apply_reset();
        AWVALID_M = 3'b010;
        AWADDR_M1 = 32'h0002_0010;
        tick();
        checks++;
        if (AW_arbiter !== 5'd11) begin
            failures++;
            $display("FAIL single_grant: got %0d expected 11", AW_arbiter);
        end
        checks++;
        if (aw_busy !== 1'b1) begin
            failures++;
            $display("FAIL single_busy: got %0b expected 1", aw_busy);
        end
        AWREADY_S = 8'h01;
        tick();
        AWREADY_S = 8'h04;
        tick();
        AWVALID_M = '0;
        AWREADY_S = '0;
        BVALID_M  = 3'b010;
        BREADY_M  = 3'b010;
        tick();
        BVALID_M  = '0;
        BREADY_M  = '0;
        checks++;
        if (AW_arbiter !== 5'd11) begin
            failures++;
            $display("FAIL single_data_hold: got %0d expected 11", AW_arbiter);
        end
        WVALID_S = 8'h04;
        WREADY_S = 8'h04;
        tick();
        checks++;
        if (AW_arbiter !== 5'd11) begin
            failures++;
            $display("FAIL single_beat1: got %0d expected 11", AW_arbiter);
        end
        WLAST_S = 8'h04;
        tick();
        WVALID_S = '0;
        WREADY_S = '0;
        WLAST_S  = '0;
        BVALID_M = 3'b001;
        BREADY_M = 3'b001;
        tick();
        checks++;
        if (AW_arbiter !== 5'd11 || aw_busy !== 1'b1) begin
            failures++;
            $display("FAIL single_wrong_b: got %0d/%0b expected 11/1",
                     AW_arbiter, aw_busy);
        end
        BVALID_M = 3'b010;
        BREADY_M = 3'b010;
        tick();
        BVALID_M = '0;
        BREADY_M = '0;
        checks++;
        if (AW_arbiter !== 5'd0 || aw_busy !== 1'b0) begin
            failures++;
            $display("FAIL single_release: got %0d/%0b expected 0/0",
                     AW_arbiter, aw_busy);
        end
    endtask

    task automatic test_contention();
        logic [4:0] exp_code [3];
`ifdef AW_RR_ARB_EN
        exp_code = '{5'd2, 5'd10, 5'd18};
`else
        exp_code = '{5'd2, 5'd2, 5'd2};
`endif
        apply_reset();
        AWADDR_M0 = 32'h0001_0000;
        AWADDR_M1 = 32'h0001_0100;
        AWADDR_M2 = 32'h0001_FFFC;
        AWVALID_M = 3'b111;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (AW_arbiter !== exp_code[i]) begin
                failures++;
                $display("FAIL contention_grant%0d: got %0d expected %0d",
                         i, AW_arbiter, exp_code[i]);
            end
            AWREADY_S = 8'h02;
            WVALID_S  = 8'h02;
            WREADY_S  = 8'h02;
            WLAST_S   = 8'h02;
            tick();
            AWREADY_S = '0;
            WVALID_S  = '0;
            WREADY_S  = '0;
            WLAST_S   = '0;
            BVALID_M  = 3'b111;
            BREADY_M  = 3'b111;
            tick();
            BVALID_M  = '0;
            BREADY_M  = '0;
            checks++;
            if (AW_arbiter !== 5'd0) begin
                failures++;
                $display("FAIL contention_gap%0d: got %0d expected 0",
                         i, AW_arbiter);
            end
        end
        AWVALID_M = '0;
        tick();
    endtask

    task automatic test_decode();
        logic [31:0] addr_tab [11];
        logic [4:0]  exp_tab  [11];
        addr_tab = '{32'h0000_3FFC, 32'h0000_4000, 32'h0001_FFFF,
                     32'h0002_0000, 32'h1000_03FF, 32'h1000_0400,
                     32'h1001_0000, 32'h201F_FFFF, 32'h2020_0000,
                     32'h3000_FFFF, 32'h3001_0000};
        exp_tab  = '{5'd1, 5'd8, 5'd2, 5'd3, 5'd4, 5'd8,
                     5'd5, 5'd6, 5'd8, 5'd7, 5'd8};
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            AWADDR_M0 = addr_tab[i];
            AWVALID_M = 3'b001;
            tick();
            checks++;
            if (AW_arbiter !== exp_tab[i]) begin
                failures++;
                $display("FAIL decode_%08h: got %0d expected %0d",
                         addr_tab[i], AW_arbiter, exp_tab[i]);
            end
            finish_burst(0, int'(exp_tab[i]) - 1);
        end
    endtask

    task automatic test_decode_miss();
        apply_reset();
        AWADDR_M0 = 32'h4000_0000;
        AWVALID_M = 3'b001;
        tick();
        checks++;
        if (AW_arbiter !== 5'd8) begin
            failures++;
            $display("FAIL miss_grant: got %0d expected 8", AW_arbiter);
        end
        AWVALID_M = '0;
        tick();
        tick();
        checks++;
        if (AW_arbiter !== 5'd8 || aw_busy !== 1'b1) begin
            failures++;
            $display("FAIL miss_awvalid_drop: got %0d/%0b expected 8/1",
                     AW_arbiter, aw_busy);
        end
        finish_burst(0, 7);
        checks++;
        if (AW_arbiter !== 5'd0) begin
            failures++;
            $display("FAIL miss_release: got %0d expected 0", AW_arbiter);
        end
    endtask

    task automatic test_early_w();
        apply_reset();
        AWADDR_M0 = 32'h2000_0100;
        AWVALID_M = 3'b001;
        tick();
        checks++;
        if (AW_arbiter !== 5'd6) begin
            failures++;
            $display("FAIL early_grant: got %0d expected 6", AW_arbiter);
        end
        WVALID_S = 8'h20;
        WREADY_S = 8'h20;
        WLAST_S  = 8'h20;
        tick();
        WVALID_S = '0;
        WREADY_S = '0;
        WLAST_S  = '0;
        tick();
        checks++;
        if (AW_arbiter !== 5'd6) begin
            failures++;
            $display("FAIL early_hold: got %0d expected 6", AW_arbiter);
        end
        AWREADY_S = 8'h20;
        tick();
        AWREADY_S = '0;
        AWVALID_M = '0;
        BVALID_M  = 3'b001;
        BREADY_M  = 3'b001;
        tick();
        BVALID_M  = '0;
        BREADY_M  = '0;
        checks++;
        if (AW_arbiter !== 5'd0 || aw_busy !== 1'b0) begin
            failures++;
            $display("FAIL early_skip_data: got %0d/%0b expected 0/0",
                     AW_arbiter, aw_busy);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        AWADDR_M1 = 32'h0002_0010;
        AWVALID_M = 3'b010;
        tick();
        AWREADY_S = 8'h04;
        tick();
        AWVALID_M = '0;
        AWREADY_S = '0;
        WVALID_S  = 8'h04;
        WREADY_S  = 8'h04;
        tick();
        checks++;
        if (AW_arbiter !== 5'd11) begin
            failures++;
            $display("FAIL mid_before: got %0d expected 11", AW_arbiter);
        end
        ARESETn = 1'b0;
        #1;
        checks++;
        if (AW_arbiter !== 5'd0 || aw_busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_async_clear: got %0d/%0b expected 0/0",
                     AW_arbiter, aw_busy);
        end
        #1;
        clear_inputs();
        ARESETn = 1'b1;
        tick();
        AWADDR_M0 = 32'h0001_0000;
        AWADDR_M1 = 32'h0001_0000;
        AWADDR_M2 = 32'h0001_0000;
        AWVALID_M = 3'b111;
        tick();
        checks++;
        if (AW_arbiter !== 5'd2) begin
            failures++;
            $display("FAIL mid_regrant: got %0d expected 2", AW_arbiter);
        end
        AWVALID_M = 3'b001;
        finish_burst(0, 1);
        checks++;
        if (AW_arbiter !== 5'd0) begin
            failures++;
            $display("FAIL mid_release: got %0d expected 0", AW_arbiter);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ARESETn  = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_decode();
        test_decode_miss();
        test_early_w();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
